// File: rtl/univ_shift_pkg.sv
// rtl/univ_shift_pkg.sv - mode encodings, FSM states and helpers for univ_shift_reg
package univ_shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FIN   = 2'b10
  } state_t;

  // True for the two modes that move data (and so may start a burst)
  function automatic logic is_shift_mode(input logic [1:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// rtl/usr_bit_cell.sv - one register bit: 4:1 next-value mux plus async-reset flop
module usr_bit_cell
  import univ_shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_sel,
  input  logic       i_par,
  input  logic       i_from_hi,
  input  logic       i_from_lo,
  output logic       o_q
);

  logic r_q;
  logic w_d;

  // Select the next value: keep, take upper neighbour, take lower neighbour, or load
  always_comb begin
    w_d = r_q;
    case (i_sel)
      MODE_HOLD: w_d = r_q;
      MODE_SHR:  w_d = i_from_hi;
      MODE_SHL:  w_d = i_from_lo;
      default:   w_d = i_par;
    endcase
  end

  // Storage flop, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with burst sequencer; optional rotate via UNIV_SHIFT_ROTATE_EN
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
`ifdef UNIV_SHIFT_ROTATE_EN
  input  logic             rotate,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_remaining;
  logic [1:0]       r_dir;
  logic [1:0]       w_op;
  logic             w_burst_go;
  logic             w_rot_now;
  logic             w_msb_in;
  logic             w_lsb_in;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

`ifdef UNIV_SHIFT_ROTATE_EN
  logic r_rot;

  // Rotate is taken live in direct mode and frozen for the length of a burst
  assign w_rot_now = (r_state == IDLE) ? rotate : r_rot;

  // Latch the rotate choice when a burst is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rot <= 1'b0;
    end else if (w_burst_go) begin
      r_rot <= rotate;
    end
  end
`else
  assign w_rot_now = 1'b0;
`endif

  // Bits entering at each end: wrapped-around bit when rotating, else serial input
  assign w_msb_in = w_rot_now ? q[0]       : ser_in_msb;
  assign w_lsb_in = w_rot_now ? q[WIDTH-1] : ser_in_lsb;
  assign w_hi     = {w_msb_in, q[WIDTH-1:1]};
  assign w_lo     = {q[WIDTH-2:0], w_lsb_in};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    usr_bit_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .i_sel     (w_op),
      .i_par     (par_in[gi]),
      .i_from_hi (w_hi[gi]),
      .i_from_lo (w_lo[gi]),
      .o_q       (q[gi])
    );
  end

  assign ser_out_msb = q[WIDTH-1];
  assign ser_out_lsb = q[0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, per-cycle operation and handshake; busy also covers the accepting cycle
  always_comb begin
    w_next     = r_state;
    w_op       = MODE_HOLD;
    w_burst_go = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && is_shift_mode(mode)) begin
          if (count == '0) begin
            w_next = FIN;
          end else begin
            w_op       = mode;
            w_burst_go = 1'b1;
            busy       = 1'b1;
            w_next     = (count == CNT_W'(1)) ? FIN : SHIFT;
          end
        end else begin
          w_op = mode;
        end
      end
      SHIFT: begin
        w_op = r_dir;
        busy = 1'b1;
        if (r_remaining == CNT_W'(1)) begin
          w_next = FIN;
        end
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Burst bookkeeping: direction latched at start, remaining shifts counted down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
      r_dir       <= MODE_HOLD;
    end else if (w_burst_go) begin
      r_remaining <= count - CNT_W'(1);
      r_dir       <= mode;
    end else if (r_state == SHIFT) begin
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

endmodule
